// File: rtl/pipelined_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_ripple_adder
// Brief    : WIDTH-bit adder cut into STAGES ripple-carry slices with the
//            carry registered between slices; valid/ready with global stall.
//            Optional signed-overflow output enabled by PIPE_ADD_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_ripple_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CHUNK = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_cfg
        $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_v;

    logic [WIDTH-1:0]  w_a_in   [STAGES];
    logic [WIDTH-1:0]  w_b_in   [STAGES];
    logic [WIDTH-1:0]  w_sum_in [STAGES];
    logic [WIDTH-1:0]  w_sum_nxt[STAGES];
    logic [STAGES-1:0] w_c_in;
    logic [STAGES-1:0] w_c_nxt;
    logic [STAGES-1:0] w_v_in;
    logic              w_advance;

    assign w_advance = !r_v[STAGES-1] || out_ready;
    assign in_ready  = w_advance;

    // Each slice is fed by the port inputs (slice 0) or by its predecessor's registers.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage_in
        if (k == 0) begin : g_first
            assign w_a_in[k]   = a;
            assign w_b_in[k]   = b;
            assign w_sum_in[k] = '0;
            assign w_c_in[k]   = cin;
            assign w_v_in[k]   = in_valid;
        end else begin : g_next
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_sum_in[k] = r_sum[k-1];
            assign w_c_in[k]   = r_c[k-1];
            assign w_v_in[k]   = r_v[k-1];
        end
    end

    always_comb begin
        logic v_carry;
        v_carry = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_sum_nxt[k] = w_sum_in[k];
            v_carry      = w_c_in[k];
            for (int j = 0; j < CHUNK; j++) begin
                w_sum_nxt[k][k*CHUNK+j] = w_a_in[k][k*CHUNK+j] ^ w_b_in[k][k*CHUNK+j] ^ v_carry;
                v_carry = (w_a_in[k][k*CHUNK+j] & w_b_in[k][k*CHUNK+j]) |
                          (v_carry & (w_a_in[k][k*CHUNK+j] ^ w_b_in[k][k*CHUNK+j]));
            end
            w_c_nxt[k] = v_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c <= '0;
            r_v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else if (w_advance) begin
            r_c <= w_c_nxt;
            r_v <= w_v_in;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= w_a_in[k];
                r_b[k]   <= w_b_in[k];
                r_sum[k] <= w_sum_nxt[k];
            end
        end
    end

    assign sum       = r_sum[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign out_valid = r_v[STAGES-1];

`ifdef PIPE_ADD_OVF_EN
    logic r_ovf;
    logic w_ovf_nxt;

    // Carry into the MSB is recovered as a^b^sum at that bit.
    assign w_ovf_nxt = w_c_nxt[STAGES-1] ^
                       (w_a_in[STAGES-1][WIDTH-1] ^ w_b_in[STAGES-1][WIDTH-1] ^
                        w_sum_nxt[STAGES-1][WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_advance) begin
            r_ovf <= w_ovf_nxt;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_ripple_adder
// Brief    : Scoreboard bench for pipelined_ripple_adder (8/4 directed plus
//            exhaustive 4/2 instance); ovf checks under PIPE_ADD_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_ripple_adder;

    localparam int S  = 4;
    localparam int XS = 2;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [7:0] a, b, sum;
    logic       x_in_valid, x_in_ready, x_cin, x_out_valid, x_cout;
    logic       x_out_ready;
    logic [3:0] x_a, x_b, x_sum;
`ifdef PIPE_ADD_OVF_EN
    logic       ovf, x_ovf;
`endif

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(8), .STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef PIPE_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipelined_ripple_adder #(.WIDTH(4), .STAGES(XS)) u_dut_x (
        .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .a(x_a), .b(x_b), .cin(x_cin), .out_valid(x_out_valid), .out_ready(x_out_ready),
        .sum(x_sum), .cout(x_cout)
`ifdef PIPE_ADD_OVF_EN
        , .ovf(x_ovf)
`endif
    );

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
        bit         chk_lat;
    } exp_t;

    exp_t sb[$];
    exp_t xsb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitors: pop one expected result per output transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got sum 0x%0h, expected no output", sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", sum, e.sum);
                check("cout", cout, e.cout);
`ifdef PIPE_ADD_OVF_EN
                check("ovf", ovf, e.ovf);
`endif
                if (e.chk_lat) check("latency", cyc - e.cyc, S);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && x_out_valid && x_out_ready) begin
            if (xsb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL x_unexpected_output: got sum 0x%0h, expected no output", x_sum);
            end else begin
                exp_t e;
                e = xsb.pop_front();
                check("x_sum", x_sum, e.sum);
                check("x_cout", x_cout, e.cout);
`ifdef PIPE_ADD_OVF_EN
                check("x_ovf", x_ovf, e.ovf);
`endif
                check("x_latency", cyc - e.cyc, XS);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [7:0] es, input logic ec, input logic eo, input bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc; e.chk_lat = lat;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic x_send(input logic [3:0] va, input logic [3:0] vb, input logic vc);
        exp_t e;
        int   s;
        logic [4:0] s5;
        s  = int'(va) + int'(vb) + int'(vc);
        s5 = s[4:0];
        x_a = va; x_b = vb; x_cin = vc; x_in_valid = 1'b1;
        @(negedge clk);
        e.sum     = {4'h0, s5[3:0]};
        e.cout    = s5[4];
        e.ovf     = (va[3] == vb[3]) && (s5[3] != va[3]);
        e.cyc     = cyc;
        e.chk_lat = 1'b1;
        if (x_in_ready) xsb.push_back(e);
        check("x_in_ready", x_in_ready, 1);
        @(posedge clk);
        #1;
        x_in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        x_in_valid = 1'b0; x_out_ready = 1'b1; x_a = '0; x_b = '0; x_cin = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_x_out_valid", x_out_valid, 0);
`ifdef PIPE_ADD_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        idle(2);
        rst_n = 1'b1;
        idle(6);
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Wrap-around
        send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Back-to-back stream
        for (int i = 0; i < 16; i++) begin
            logic [7:0] vi;
            vi = 8'(i);
            send(vi, vi + 8'd1, 1'b0, 8'(2 * i + 1), 1'b0, 1'b0, 1'b1);
        end
        idle(6);

        // Fill with output blocked, then stall three cycles
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
        send(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0);
        send(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        send(8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_sum_held", sum, 8'h33);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(8);

        // Reset with items in flight
        out_ready = 1'b0;
        send(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
        send(8'h04, 8'h05, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0);
        send(8'h06, 8'h07, 1'b0, 8'h0D, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("pre_reset_out_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_in_ready", in_ready, 1);
        sb.delete();
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(8);
        send(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1);

        // Signed-overflow corner vectors
        send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
        send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Exhaustive narrow instance
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            x_send(v[3:0], v[7:4], v[8]);
        end

        for (int t = 0; t < 20 && (sb.size() != 0 || xsb.size() != 0); t++) idle(1);
        check("drain_main", sb.size(), 0);
        check("drain_x", xsb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
